// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and constants for the APB master arbiter.
// Contents:
//   apb_state_e - APB master protocol phase (IDLE -> SETUP -> ACCESS)
//   DefaultDw   - default data width
//   DefaultAw   - default address width
//   cnt_width() - timeout counter width; a zero TIMEOUT still needs one bit
package apb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  localparam int unsigned DefaultDw = 32;
  localparam int unsigned DefaultAw = 32;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB master-side bus bundle (Mp* signals of the APB interconnect).
// Modports:
//   master - drives MpADDR/MpSELx/MpENABLE/MpWRITE/MpWDATA, samples MpRDATA/MpREADY/MpSLVERR
//   slave  - the opposite direction, for the interconnect or a bench slave model
interface apb_master_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic [AW-1:0] MpADDR;
  logic          MpSELx;
  logic          MpENABLE;
  logic          MpWRITE;
  logic [DW-1:0] MpWDATA;
  logic [DW-1:0] MpRDATA;
  logic          MpREADY;
  logic          MpSLVERR;

  modport master (
    output MpADDR, MpSELx, MpENABLE, MpWRITE, MpWDATA,
    input  MpRDATA, MpREADY, MpSLVERR
  );

  modport slave (
    input  MpADDR, MpSELx, MpENABLE, MpWRITE, MpWDATA,
    output MpRDATA, MpREADY, MpSLVERR
  );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset, pointer -> 0
//   req     - request vector
//   advance - the current grant was taken; move the pointer past it
//   gnt     - one-hot grant, first set req bit at or above the pointer (wrapping)
module apb_master_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] gnt_idx;
  logic [31:0]     sum;
  logic            found;

  // Scan upward from the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = 32'(ptr_q) + 32'(k);
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      if (!found && req[sum[PtrW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[PtrW-1:0];
      end
    end
    gnt[gnt_idx] = found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin arbitration,
// sequences IDLE -> SETUP -> ACCESS, and turns a hung slave into an error after TIMEOUT
// ACCESS cycles without MpREADY (TIMEOUT = 0 disables this).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req_valid/req_write  - per-requester request and direction, held until req_ready
//   req_addr/req_wdata   - per-requester address and write data
//   req_ready            - one-hot accept pulse (combinational, IDLE only)
//   rsp_valid            - one-hot one-cycle completion pulse to the owner
//   rsp_rdata            - read data, 0 for writes, errors and non-completion cycles
//   rsp_err              - slave error or timeout, qualified by rsp_valid
//   apb                  - APB master bus (Mp* signals)
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned AW      = DefaultAw,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_write,
  input  logic [AW-1:0]      req_addr  [NUM_REQ],
  input  logic [DW-1:0]      req_wdata [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  apb_master_arbiter_if.master apb
);

  localparam int unsigned    CntW    = cnt_width(TIMEOUT);
  localparam bit             TimeoutEn = (TIMEOUT != 0);
  localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT - 1) : '0;

  apb_state_e state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0] gnt;
  logic               timeout_hit;

  apb_master_arbiter_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .advance(|req_ready),
    .gnt    (gnt)
  );

  // Grants are only offered while idle and never during reset.
  assign req_ready   = (state_q == StIdle && !rst) ? gnt : '0;
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req_ready) begin
          state_d = StSetup;
          owner_d = req_ready;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
              addr_d  = req_addr[i];
              wdata_d = req_wdata[i];
              write_d = req_write[i];
            end
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        if (apb.MpREADY) begin
          state_d     = StIdle;
          rsp_valid_d = owner_q;
          rsp_err_d   = apb.MpSLVERR;
          rsp_rdata_d = (!write_q && !apb.MpSLVERR) ? apb.MpRDATA : '0;
        end else if (timeout_hit) begin
          // Hung slave: abandon the transfer and report an error.
          state_d     = StIdle;
          rsp_valid_d = owner_q;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign apb.MpADDR   = addr_q;
  assign apb.MpWDATA  = wdata_q;
  assign apb.MpWRITE  = write_q;
  assign apb.MpSELx   = (state_q != StIdle);
  assign apb.MpENABLE = (state_q == StAccess);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model (pending table, round-robin
// pointer, and a per-transfer schedule of SETUP/ACCESS/response cycles).
module tb_apb_master_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [AW-1:0] req_addr  [NR];
  logic [DW-1:0] req_wdata [NR];
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  apb_master_arbiter_if #(.AW(AW), .DW(DW)) apb ();

  apb_master_arbiter #(
    .DW(DW), .AW(AW), .NUM_REQ(NR), .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .apb      (apb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Requester-side pending table (also what is driven onto req_*).
  logic [NR-1:0] pend = '0;
  logic [NR-1:0] pend_write = '0;
  logic [AW-1:0] p_addr  [NR];
  logic [DW-1:0] p_wdata [NR];
  bit gen_en = 0;
  bit refill = 0;

  // Model of the shared bus.
  int ptr = 0;
  bit busy = 0;
  int tg, a_len, rsp_c, own;
  bit t_out;
  logic t_write;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic last_write = 1'b0;

  // Slave behaviour for the transfer on the bus, and for the next one granted.
  int cur_w = 0, nxt_w = 0;
  bit cur_err = 0, nxt_err = 0;
  logic [DW-1:0] cur_rdata = '0, nxt_rdata = '0;
  int acc_k = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    pend[i] = 1'b1;
    pend_write[i] = w;
    p_addr[i] = a;
    p_wdata[i] = d;
  endtask

  task automatic model_check(input bit r);
    logic [NR-1:0] ev, eg;
    logic ee, esel, een;
    logic [DW-1:0] ed;
    int g;
    if (r) begin
      check_eq("ready_in_rst", req_ready, '0);
      busy = 0;
      ptr = 0;
      last_addr = '0;
      last_wdata = '0;
      last_write = 1'b0;
      return;
    end
    // Response
    ev = '0; ee = 1'b0; ed = '0;
    if (busy && cyc == rsp_c) begin
      ev = NR'(1) << own;
      ee = t_out ? 1'b1 : cur_err;
      ed = (t_out || cur_err || t_write) ? '0 : cur_rdata;
      busy = 0;
    end
    check_eq("rsp_valid", rsp_valid, ev);
    check_eq("rsp_err", rsp_err, ee);
    check_eq("rsp_rdata", rsp_rdata, ed);
    // Bus phase and stable address/data
    esel = busy && cyc >= tg + 1 && cyc <= tg + 1 + a_len;
    een  = busy && cyc >= tg + 2 && cyc <= tg + 1 + a_len;
    check_eq("MpSELx", apb.MpSELx, esel);
    check_eq("MpENABLE", apb.MpENABLE, een);
    check_eq("MpADDR", apb.MpADDR, last_addr);
    check_eq("MpWRITE", apb.MpWRITE, last_write);
    check_eq("MpWDATA", apb.MpWDATA, last_wdata);
    // Arbitration
    eg = '0; g = -1;
    if (!busy) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && pend[(ptr + k) % NR]) g = (ptr + k) % NR;
      end
    end
    if (g >= 0) eg = NR'(1) << g;
    check_eq("req_ready", req_ready, eg);
    if (g >= 0) begin
      busy = 1; tg = cyc; own = g;
      t_write = pend_write[g];
      last_addr = p_addr[g]; last_wdata = p_wdata[g]; last_write = pend_write[g];
      pend[g] = 1'b0;
      ptr = (g + 1) % NR;
      cur_w = nxt_w; cur_err = nxt_err; cur_rdata = nxt_rdata;
      t_out = (cur_w >= TO);
      a_len = t_out ? TO : cur_w + 1;
      rsp_c = tg + 2 + a_len;
      if (gen_en) begin
        nxt_w = $urandom_range(0, 5);
        nxt_err = ($urandom_range(0, 3) == 0);
        nxt_rdata = $urandom;
      end
    end
  endtask

  task automatic step(input bit r);
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    for (int i = 0; i < NR; i++) begin
      if (gen_en && pend[i] && $urandom_range(0, 31) == 0) pend[i] = 1'b0;
      else if ((refill || (gen_en && $urandom_range(0, 2) == 0)) && !pend[i])
        set_req(i, 1'($urandom), $urandom, $urandom);
      req_addr[i] = p_addr[i];
      req_wdata[i] = p_wdata[i];
    end
    req_valid = pend;
    req_write = pend_write;
    if (apb.MpSELx && apb.MpENABLE) begin
      if (acc_k >= cur_w) begin
        apb.MpREADY = 1'b1; apb.MpSLVERR = cur_err; apb.MpRDATA = cur_rdata;
      end else begin
        apb.MpREADY = 1'b0; apb.MpSLVERR = 1'($urandom); apb.MpRDATA = $urandom;
      end
      acc_k++;
    end else begin
      acc_k = 0;
      apb.MpREADY = 1'($urandom); apb.MpSLVERR = 1'($urandom); apb.MpRDATA = $urandom;
    end
    #3;
    model_check(r);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      p_addr[i] = '0; p_wdata[i] = '0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    rst = 1'b1; req_valid = '0; req_write = '0;
    apb.MpREADY = 1'b0; apb.MpSLVERR = 1'b0; apb.MpRDATA = '0;
    step(1); step(1);
    step(0); step(0);
    // Single write, zero wait
    set_req(0, 1'b1, 32'h84, 32'hDEADBEEF);
    nxt_w = 0; nxt_err = 0; nxt_rdata = 32'hCAFE0000;
    repeat (6) step(0);
    // Read, two wait states
    set_req(1, 1'b0, 32'h100, 32'h0);
    nxt_w = 2; nxt_rdata = 32'h12345678;
    repeat (8) step(0);
    // Slave error on a read
    set_req(0, 1'b0, 32'h200, 32'h0);
    nxt_w = 1; nxt_err = 1; nxt_rdata = 32'hFFFF;
    repeat (7) step(0);
    // Timeout, then a new request must still be accepted
    set_req(1, 1'b0, 32'h300, 32'h0);
    nxt_w = 1000; nxt_err = 0;
    repeat (3) step(0);
    set_req(0, 1'b1, 32'h304, 32'h55);
    nxt_w = 0;
    repeat (12) step(0);
    // Both requesters held continuously after reset
    step(1);
    refill = 1;
    repeat (14) step(0);
    refill = 0;
    repeat (10) step(0);
    // Reset during an ACCESS wait state
    set_req(1, 1'b0, 32'h400, 32'h0);
    nxt_w = 3;
    repeat (4) step(0);
    step(1);
    set_req(1, 1'b1, 32'h500, 32'h11);
    set_req(0, 1'b1, 32'h504, 32'h22);
    repeat (10) step(0);
    // Random traffic
    gen_en = 1;
    nxt_w = $urandom_range(0, 5); nxt_err = ($urandom_range(0, 3) == 0); nxt_rdata = $urandom;
    repeat (600) step(0);
    gen_en = 0;
    repeat (20) step(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ on-chip requesters (CPU bus bridge, DMA, debug) using round-robin arbitration.
- Drives the Mp* inputs of the APB interconnect directly.
- Sequences the APB protocol IDLE -> SETUP -> ACCESS, honours wait states, and converts a hung slave into an error response using a timeout counter.

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- NUM_REQ, 2, number of requesters (>=1).
- TIMEOUT, 255, maximum ACCESS cycles without MpREADY before forced error; 0 disables the timeout.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  NUM_REQ  per-requester transfer request, held until its req_ready.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  [AW-1:0] x NUM_REQ (unpacked)  transfer address.
- req_wdata  in  [DW-1:0] x NUM_REQ (unpacked)  write data.
- req_ready  out  NUM_REQ  one-hot accept pulse; request is latched this cycle.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  slave error or timeout, qualified by rsp_valid.
- MpADDR  out  AW  APB address.
- MpSELx  out  1  APB select.
- MpENABLE  out  1  APB enable.
- MpWRITE  out  1  APB direction.
- MpWDATA  out  DW  APB write data.
- MpRDATA  in  DW  APB read data.
- MpREADY  in  1  APB ready.
- MpSLVERR  in  1  APB slave error.

Behaviour:
- Reset (rst=1 at an edge):
  - State becomes IDLE, the round-robin pointer becomes 0, and the timeout counter is cleared.
  - All registered outputs go to 0: MpADDR, MpSELx, MpENABLE, MpWRITE, MpWDATA, rsp_valid, rsp_rdata, rsp_err.
  - req_ready is 0 while rst=1.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Outputs: MpSELx=0, MpENABLE=0.
  - If any req_valid is set, the arbiter picks the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - req_ready[g] is asserted combinationally in the same cycle.
  - At the edge: addr, wdata and write are latched into the Mp* registers, g is stored as owner, pointer <= (g+1) mod NUM_REQ, and the FSM moves to SETUP.
  - With no request, the FSM stays in IDLE and the Mp address/data registers hold their last values.
- SETUP:
  - Outputs: MpSELx=1, MpENABLE=0, exactly one cycle.
  - Next state is always ACCESS; the counter is cleared.
- ACCESS:
  - Outputs: MpSELx=1, MpENABLE=1.
  - MpADDR, MpWRITE and MpWDATA stay stable from SETUP through the end of ACCESS.
  - If MpREADY=1: next state IDLE. Registered response in the following cycle: rsp_valid[owner]=1, rsp_err=MpSLVERR, rsp_rdata = MpRDATA only if read and !MpSLVERR, else 0.
  - If MpREADY=0: the counter increments. When counter == TIMEOUT-1 and TIMEOUT != 0, the transfer is abandoned: next state IDLE, MpSELx and MpENABLE drop, and the response is rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0.
  - Timeout counter width: $clog2(TIMEOUT+1).
- Latency:
  - Zero-wait-state transfer: the req_ready cycle is followed by SETUP, then ACCESS, then the rsp_valid cycle. Response arrives 3 cycles after acceptance.
  - Each wait state adds one cycle.
  - Minimum issue interval is 3 cycles, because a new grant is possible in the same cycle as the previous rsp_valid (the FSM is already in IDLE).
- rsp_valid and rsp_rdata are 0 in every cycle that is not a completion cycle.
- Simultaneous requests: only one grant per IDLE cycle. The others stay pending and are served in round-robin order, with no starvation.
- A requester deasserting req_valid before req_ready: its request is dropped silently, which is legal.
- Reset mid-transfer: the aborted transfer produces no rsp_valid, and MpSELx/MpENABLE are 0 after the reset edge.
- MpSLVERR is sampled only when MpREADY=1 in ACCESS.
- NUM_REQ=1: the arbiter degenerates to a pass-through, and the pointer stays 0.

Decomposition:
- apb_pkg: state enum typedef (IDLE, SETUP, ACCESS) and constants for default DW/AW; shared with the interconnect and slave blocks.
- Sub-module rr_arbiter: parameter NUM_REQ.
  - Inputs: clk, rst, req vector, advance strobe.
  - Output: one-hot gnt.
  - Owns the pointer register.
- apb_master_arbiter keeps the FSM, timeout counter, Mp* registers and response registers.

Test Plan:
- Single write, zero wait:
  - Stimulus: req0 write addr 0x84, data 0xDEADBEEF; MpREADY=1 in ACCESS.
  - Required: SETUP then ACCESS with stable addr/data, rsp_valid=01 three cycles after req_ready, rsp_err=0, rsp_rdata=0.
- Read with 2 wait states:
  - Stimulus: req1 read 0x100; MpREADY low for 2 ACCESS cycles, then high with MpRDATA=0x12345678.
  - Required: MpENABLE high for 3 cycles, rsp_valid=10, rsp_rdata=0x12345678.
- Simultaneous requests:
  - Stimulus: req0 and req1 held continuously after reset.
  - Required: grants 0,1,0,1, each new grant coinciding with the previous rsp_valid.
- Slave error:
  - Stimulus: read with MpSLVERR=1, MpRDATA=0xFFFF.
  - Required: rsp_err=1, rsp_rdata=0.
- Timeout:
  - Stimulus: TIMEOUT=4, MpREADY stuck 0.
  - Required: exactly 4 ACCESS cycles, then MpSELx=0, rsp_valid with rsp_err=1, FSM back in IDLE and accepting new requests.
- Reset mid-ACCESS:
  - Stimulus: assert rst for 1 cycle during a wait state.
  - Required: all outputs 0 next cycle, no rsp_valid, and the first grant afterwards goes to requester 0.
